// File: rtl/sid_bus_master_if.sv
// Host request, bus-cycle and read-response signals of the SID bus master.
// Latency: none, this is wiring only.
// Backpressure: req_valid/req_ready on the request side. The response side has no backpressure.
// Ports (master modport = the bus master's own view):
//   in : req_valid, req_res, req_r_w_n, req_chip, req_addr, req_data, data_i
//        (plus req_delay when SID_BUS_MASTER_DELAY_EN is defined)
//   out: req_ready, phi2, r_w_n, addr, data, cs, res, rsp_valid, rsp_chip, rsp_data
interface sid_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_res;
  logic       req_r_w_n;
  logic       req_chip;
  logic [4:0] req_addr;
  logic [7:0] req_data;
`ifdef SID_BUS_MASTER_DELAY_EN
  logic [15:0] req_delay;
`endif
  logic       phi2;
  logic       r_w_n;
  logic [4:0] addr;
  logic [7:0] data;
  logic [1:0] cs;
  logic       res;
  logic [7:0] data_i;
  logic       rsp_valid;
  logic       rsp_chip;
  logic [7:0] rsp_data;

  modport master (
    input  req_valid, req_res, req_r_w_n, req_chip, req_addr, req_data, data_i,
`ifdef SID_BUS_MASTER_DELAY_EN
    input  req_delay,
`endif
    output req_ready, phi2, r_w_n, addr, data, cs, res, rsp_valid, rsp_chip, rsp_data
  );

  modport slave (
    output req_valid, req_res, req_r_w_n, req_chip, req_addr, req_data, data_i,
`ifdef SID_BUS_MASTER_DELAY_EN
    output req_delay,
`endif
    input  req_ready, phi2, r_w_n, addr, data, cs, res, rsp_valid, rsp_chip, rsp_data
  );
endinterface

// File: rtl/sid_bus_master.sv
// SID bus initiator. It turns host register requests into PHI2-timed 6510-style bus cycles.
// Latency: a request is accepted at a PHI2 rise point. Read data returns HALF_CYCLE_CLKS+1 clks later.
// Backpressure: req_ready is high only at rise points, at most one access per PHI2 period; rsp is never stalled.
// Ports: clk, rst_n (async active-low); bus (sid_bus_master_if.master): host request, bus outputs
//   phi2/r_w_n/addr/data/cs/res, read data input data_i, read response rsp_*.
// Optional: define SID_BUS_MASTER_DELAY_EN to add req_delay and a WAIT state (per-request PHI2-cycle delay).
module sid_bus_master #(
  parameter int HALF_CYCLE_CLKS = 12,  // clk per PHI2 half-period, >= 2
  parameter int RES_CYCLES      = 10   // PHI2 cycles res is held after a reset
) (
  input logic              clk,
  input logic              rst_n,
  sid_bus_master_if.master bus
);
  localparam int PH_W = $clog2(HALF_CYCLE_CLKS);
  localparam int RC_W = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_CYCLE_CLKS - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RES_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_ACCESS,
    ST_COMMIT
`ifdef SID_BUS_MASTER_DELAY_EN
    , ST_WAIT
`endif
  } state_t;

  function automatic logic [1:0] chip_sel(input logic chip);
    return chip ? 2'b10 : 2'b01;
  endfunction

  // PHI2 generator. It runs freely from reset and is unaffected by reset requests.
  logic [PH_W-1:0] ph_cnt;
  logic            phi2_q;
  logic            rise_pt;
  logic            fall_pt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_cnt <= '0;
      phi2_q <= 1'b0;
    end else if (ph_cnt == PH_LAST) begin
      ph_cnt <= '0;
      phi2_q <= ~phi2_q;
    end else begin
      ph_cnt <= ph_cnt + 1'b1;
    end
  end

  assign rise_pt = !phi2_q && (ph_cnt == PH_LAST);
  assign fall_pt =  phi2_q && (ph_cnt == PH_LAST);

  state_t          state_q,     state_d;
  logic [RC_W-1:0] res_cnt_q,   res_cnt_d;
  logic            r_w_n_q,     r_w_n_d;
  logic [4:0]      addr_q,      addr_d;
  logic [7:0]      data_q,      data_d;
  logic [1:0]      cs_q,        cs_d;
  logic            res_q,       res_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_chip_q,  rsp_chip_d;
  logic [7:0]      rsp_data_q,  rsp_data_d;
  logic            cur_rd_q,    cur_rd_d;    // in-flight request is a read
  logic            cur_chip_q,  cur_chip_d;  // in-flight request target chip
  logic            req_ready_c;
`ifdef SID_BUS_MASTER_DELAY_EN
  logic [15:0]     wait_cnt_q,  wait_cnt_d;  // PHI2 cycles of delay still to run
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      res_cnt_q   <= '0;
      r_w_n_q     <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      cs_q        <= '0;
      res_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_chip_q  <= 1'b0;
      rsp_data_q  <= '0;
      cur_rd_q    <= 1'b1;
      cur_chip_q  <= 1'b0;
`ifdef SID_BUS_MASTER_DELAY_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      res_cnt_q   <= res_cnt_d;
      r_w_n_q     <= r_w_n_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cs_q        <= cs_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_chip_q  <= rsp_chip_d;
      rsp_data_q  <= rsp_data_d;
      cur_rd_q    <= cur_rd_d;
      cur_chip_q  <= cur_chip_d;
`ifdef SID_BUS_MASTER_DELAY_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  // Bus outputs are registered. Each *_d value is what the bus shows from the next clk.
  always_comb begin
    state_d     = state_q;
    res_cnt_d   = res_cnt_q;
    r_w_n_d     = r_w_n_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cs_d        = cs_q;
    res_d       = res_q;
    rsp_valid_d = 1'b0;
    rsp_chip_d  = rsp_chip_q;
    rsp_data_d  = rsp_data_q;
    cur_rd_d    = cur_rd_q;
    cur_chip_d  = cur_chip_q;
    req_ready_c = 1'b0;
`ifdef SID_BUS_MASTER_DELAY_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      ST_RESET: begin
        res_d = 1'b1;
        cs_d  = 2'b00;
        if (rise_pt) begin
          if (res_cnt_q == RC_LAST) begin
            res_d     = 1'b0;
            res_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            res_cnt_d = res_cnt_q + 1'b1;
          end
        end
      end

      // IDLE and the end of COMMIT share the acceptance point. Because of this,
      // back-to-back requests keep cs asserted with no idle gap.
      ST_IDLE, ST_COMMIT: begin
        req_ready_c = rise_pt;
        if (rise_pt) begin
          state_d = ST_IDLE;
          cs_d    = 2'b00;
          r_w_n_d = 1'b1;
          if (bus.req_valid) begin
            if (bus.req_res) begin
              state_d   = ST_RESET;
              res_d     = 1'b1;
              res_cnt_d = '0;
            end else begin
              cur_rd_d   = bus.req_r_w_n;
              cur_chip_d = bus.req_chip;
              addr_d     = bus.req_addr;
              if (!bus.req_r_w_n) begin
                data_d = bus.req_data;
              end
`ifdef SID_BUS_MASTER_DELAY_EN
              if (bus.req_delay != 16'd0) begin
                // Keep cs low. Address and data are set up now, and cs is asserted only when the delay ends.
                wait_cnt_d = bus.req_delay;
                state_d    = ST_WAIT;
              end else begin
                cs_d    = chip_sel(bus.req_chip);
                r_w_n_d = bus.req_r_w_n;
                state_d = ST_ACCESS;
              end
`else
              cs_d    = chip_sel(bus.req_chip);
              r_w_n_d = bus.req_r_w_n;
              state_d = ST_ACCESS;
`endif
            end
          end
        end
      end

      ST_ACCESS: begin
        if (fall_pt) begin
          state_d = ST_COMMIT;
          if (cur_rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.data_i;
            rsp_chip_d  = cur_chip_q;
            cs_d        = 2'b00;
            r_w_n_d     = 1'b1;
          end
        end
      end

`ifdef SID_BUS_MASTER_DELAY_EN
      ST_WAIT: begin
        if (rise_pt) begin
          if (wait_cnt_q == 16'd1) begin
            cs_d    = chip_sel(cur_chip_q);
            r_w_n_d = cur_rd_q;
            state_d = ST_ACCESS;
          end else begin
            wait_cnt_d = wait_cnt_q - 16'd1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_RESET;
        res_d   = 1'b1;
        cs_d    = 2'b00;
      end
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.phi2      = phi2_q;
  assign bus.r_w_n     = r_w_n_q;
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.cs        = cs_q;
  assign bus.res       = res_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_chip  = rsp_chip_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_sid_bus_master.sv
// Bench for sid_bus_master. It covers the reset sequence, directed and randomized accesses, and mid-access reset.
// Expected bus values come from PHI2 timing arithmetic counted from reset release.
module tb_sid_bus_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;                 // posedges since the last rst_n release
  logic [7:0] model_data = 8'h00;

  always #5 clk = ~clk;

  sid_bus_master_if bus ();

  sid_bus_master #(.HALF_CYCLE_CLKS(12), .RES_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Expected phi2 follows from a 24-clk period counted from reset release.
  task automatic chk_phi2();
    chk("phi2", 32'(bus.phi2), 32'((n / 12) % 2));
  endtask

  // Wait for res to drop. Until then req_ready and rsp_valid must stay low.
  task automatic reset_seq(input int exp_n, input string tag);
    int cnt;
    cnt = 0;
    while (bus.res === 1'b1 && cnt < 400) begin
      chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
      chk("rsp_in_reset", 32'(bus.rsp_valid), 32'd0);
      tick();
      cnt++;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  // One access, with every bus output checked on each clk until its PHI2 cycle ends.
  // keep=1 returns at the closing rise point so the caller can chain a back-to-back request.
  task automatic do_txn(input bit rd, input bit chip, input logic [4:0] a, input logic [7:0] wd,
                        input int dly, input logic [7:0] rv, input bit keep, output int acc_n);
    int off;
    int cnt;
    logic [1:0] sel;
    logic [1:0] exp_cs;
    logic       exp_rw;
    logic [7:0] exp_d;
    off = 24 * dly;
    sel = chip ? 2'b10 : 2'b01;
    bus.req_valid = 1'b1;
    bus.req_res   = 1'b0;
    bus.req_r_w_n = rd;
    bus.req_chip  = chip;
    bus.req_addr  = a;
    bus.req_data  = wd;
`ifdef SID_BUS_MASTER_DELAY_EN
    bus.req_delay = 16'(dly);
`endif
    cnt = 0;
    while (bus.req_ready !== 1'b1 && cnt < 60) begin
      chk("ready_gate", 32'(bus.req_ready), 32'((n % 24) == 11));
      bus.data_i = 8'($urandom);
      tick();
      cnt++;
    end
    acc_n = n;
    chk("accept_timeout", 32'(cnt < 60), 32'd1);
    if (cnt >= 60) begin
      bus.req_valid = 1'b0;
      return;
    end
    chk("accept_phase", 32'(n % 24), 32'd11);
    if (!rd) model_data = wd;
    exp_d = model_data;
    for (int k = 1; k <= off + 24; k++) begin
      tick();
      if (k == 1) begin
        // The fields are scrambled after acceptance. The DUT must have latched the request.
        bus.req_valid = 1'b0;
        bus.req_r_w_n = 1'($urandom);
        bus.req_chip  = 1'($urandom);
        bus.req_addr  = 5'($urandom);
        bus.req_data  = 8'($urandom);
      end
      chk_phi2();
      chk("res_low", 32'(bus.res), 32'd0);
      chk("ready_busy", 32'(bus.req_ready), 32'(k == off + 24));
      if (k <= off) begin
        exp_cs = 2'b00;
        exp_rw = 1'b1;
      end else if (k <= off + 12 || !rd) begin
        exp_cs = sel;
        exp_rw = rd;
        chk("addr", 32'(bus.addr), 32'(a));
        chk("data", 32'(bus.data), 32'(exp_d));
      end else begin
        exp_cs = 2'b00;
        exp_rw = 1'b1;
      end
      chk("cs", 32'(bus.cs), 32'(exp_cs));
      chk("r_w_n", 32'(bus.r_w_n), 32'(exp_rw));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(rd && k == off + 13));
      if (rd && k == off + 13) begin
        chk("rsp_data", 32'(bus.rsp_data), 32'(rv));
        chk("rsp_chip", 32'(bus.rsp_chip), 32'(chip));
      end
      bus.data_i = (k == off + 12) ? rv : 8'($urandom);
    end
    if (!keep) begin
      tick();
      chk("idle_cs", 32'(bus.cs), 32'd0);
      chk("idle_r_w_n", 32'(bus.r_w_n), 32'd1);
      chk("idle_rsp", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int acc, acc1, acc2, acc3, r, cnt;
    bit rd, ch, kp;
    int dly;
    bus.req_valid = 1'b0;
    bus.req_res   = 1'b0;
    bus.req_r_w_n = 1'b1;
    bus.req_chip  = 1'b0;
    bus.req_addr  = 5'h00;
    bus.req_data  = 8'h00;
    bus.data_i    = 8'h00;
`ifdef SID_BUS_MASTER_DELAY_EN
    bus.req_delay = 16'd0;
`endif

    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phi2", 32'(bus.phi2), 32'd0);
    chk("rst_cs", 32'(bus.cs), 32'd0);
    chk("rst_r_w_n", 32'(bus.r_w_n), 32'd1);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);

    // Release. res falls after the 10th rise point (clk 227).
    rst_n = 1'b1;
    n = 0;
    reset_seq(228, "res_release");

    // Directed write. The first acceptance happens at the first rise point after IDLE (clk 251).
    do_txn(1'b0, 1'b0, 5'h18, 8'h0F, 0, 8'h00, 1'b0, acc);
    chk("first_ready", 32'(acc), 32'd251);

    // Directed read of chip1.
    do_txn(1'b1, 1'b1, 5'h1B, 8'h00, 0, 8'hA5, 1'b0, acc);

    // Three back-to-back writes.
    do_txn(1'b0, 1'b0, 5'h00, 8'h11, 0, 8'h00, 1'b1, acc1);
    do_txn(1'b0, 1'b1, 5'h01, 8'h22, 0, 8'h00, 1'b1, acc2);
    do_txn(1'b0, 1'b0, 5'h02, 8'h33, 0, 8'h00, 1'b0, acc3);
    chk("b2b_gap1", 32'(acc2 - acc1), 32'd24);
    chk("b2b_gap2", 32'(acc3 - acc2), 32'd24);

`ifdef SID_BUS_MASTER_DELAY_EN
    do_txn(1'b0, 1'b1, 5'h04, 8'h3C, 3, 8'h00, 1'b0, acc);
    do_txn(1'b1, 1'b0, 5'h1C, 8'h00, 0, 8'h5A, 1'b0, acc);
`endif

    // Reset request. res is raised at once and held for 10 PHI2 cycles.
    bus.req_valid = 1'b1;
    bus.req_res   = 1'b1;
    cnt = 0;
    while (bus.req_ready !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("res_req_timeout", 32'(cnt < 60), 32'd1);
    r = n;
    tick();
    bus.req_valid = 1'b0;
    bus.req_res   = 1'b0;
    chk("res_req_res", 32'(bus.res), 32'd1);
    chk("res_req_cs", 32'(bus.cs), 32'd0);
    reset_seq(r + 241, "res_req_release");

    // Randomized accesses.
    for (int t = 0; t < 30; t++) begin
      rd = 1'($urandom);
      ch = 1'($urandom);
      kp = (t != 29) && ($urandom_range(0, 1) == 1);
`ifdef SID_BUS_MASTER_DELAY_EN
      dly = $urandom_range(0, 2);
`else
      dly = 0;
`endif
      do_txn(rd, ch, 5'($urandom), 8'($urandom), dly, 8'($urandom), kp, acc);
    end

    // rst_n pulse during the ACCESS half of a read.
    bus.req_valid = 1'b1;
    bus.req_res   = 1'b0;
    bus.req_r_w_n = 1'b1;
    bus.req_chip  = 1'b1;
    bus.req_addr  = 5'h0A;
    cnt = 0;
    while (bus.req_ready !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("mid_rst_timeout", 32'(cnt < 60), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    repeat (4) tick();
    chk("mid_rst_cs_before", 32'(bus.cs), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(bus.cs), 32'd0);
    chk("mid_rst_phi2", 32'(bus.phi2), 32'd0);
    chk("mid_rst_r_w_n", 32'(bus.r_w_n), 32'd1);
    chk("mid_rst_addr", 32'(bus.addr), 32'd0);
    chk("mid_rst_data", 32'(bus.data), 32'd0);
    chk("mid_rst_res", 32'(bus.res), 32'd1);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    model_data = 8'h00;
    reset_seq(228, "mid_rst_release");
    do_txn(1'b1, 1'b0, 5'h19, 8'h00, 0, 8'h3E, 1'b0, acc);
    chk("mid_rst_first_ready", 32'(acc), 32'd251);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
